// File: rtl/seg7_capture_if.sv
// Bundles the observed 7-segment pins and the decoded frame outputs of seg7_capture.
// master drives the display pins and reads the frame; slave is the capture block.
interface seg7_capture_if;
    logic [7:0] i_seg;
    logic [3:0] i_dig;
    logic [3:0] o_ones;
    logic [3:0] o_tens;
    logic [6:0] o_value;
    logic [1:0] o_dp;
    logic       o_valid;
    logic       o_err;
    logic       o_stale;

    modport master (
        output i_seg, i_dig,
        input  o_ones, o_tens, o_value, o_dp, o_valid, o_err, o_stale
    );

    modport slave (
        input  i_seg, i_dig,
        output o_ones, o_tens, o_value, o_dp, o_valid, o_err, o_stale
    );
endinterface

// File: rtl/seg7_capture.sv
// Samples a two-digit multiplexed 7-segment bus and rebuilds BCD/binary frames.
// Optional macro SEG7_CAPTURE_DP_EN: latch and report decimal points on o_dp.
module seg7_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT       = 27_000_000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    seg7_capture_if.slave  bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] DIG_ONES = 4'b1110;
    localparam logic [3:0] DIG_TENS = 4'b1101;
    localparam logic [11:0] SYNC_RST = {8'h00, 4'hF};

    typedef enum logic {COLLECT, COMMIT} state_t;

    // Returns {invalid, bcd} for segments a..g.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'd0;
            7'b0110000: r = 5'd1;
            7'b1101101: r = 5'd2;
            7'b1111001: r = 5'd3;
            7'b0110011: r = 5'd4;
            7'b1011011: r = 5'd5;
            7'b1011111: r = 5'd6;
            7'b1110000: r = 5'd7;
            7'b1111111: r = 5'd8;
            7'b1111011: r = 5'd9;
            default:    r = 5'b1_0000;
        endcase
        return r;
    endfunction

    logic [11:0]   r_sync1, r_sync2, r_prev;
    logic [SW-1:0] r_stc;
    logic          r_cap_done;
    logic [3:0]    r_ones_h, r_tens_h;
    logic          r_got_ones, r_got_tens, r_bad;
    state_t        r_state;
    logic [3:0]    r_ones, r_tens;
    logic [6:0]    r_value;
    logic          r_valid, r_err;
    logic [TW-1:0] r_cnt;

    logic [7:0] w_seg;
    logic [3:0] w_dig;
    logic       w_same, w_cap, w_cap_ones, w_cap_tens;
    logic [4:0] w_dec;
    logic       w_got_ones_n, w_got_tens_n, w_bad_n;
    logic [3:0] w_ones_h_n, w_tens_h_n;
    logic [6:0] w_value_n;
    state_t     w_state_n;
    logic       w_commit_ok, w_commit_bad;

    assign w_seg  = r_sync2[11:4];
    assign w_dig  = r_sync2[3:0];
    assign w_same = (r_sync2 == r_prev);
    assign w_dec  = f_decode(w_seg[7:1]);

    assign w_cap      = (r_stc == SW'(STABLE_CYCLES - 1)) && w_same && !r_cap_done;
    assign w_cap_ones = w_cap && (w_dig == DIG_ONES);
    assign w_cap_tens = w_cap && (w_dig == DIG_TENS);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1    <= SYNC_RST;
            r_sync2    <= SYNC_RST;
            r_prev     <= SYNC_RST;
            r_stc      <= '0;
            r_cap_done <= 1'b0;
        end else begin
            r_sync1 <= {bus.i_seg, bus.i_dig};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_same) begin
                r_stc      <= '0;
                r_cap_done <= 1'b0;
            end else begin
                if (r_stc != SW'(STABLE_CYCLES))
                    r_stc <= r_stc + 1'b1;
                if (w_cap_ones || w_cap_tens)
                    r_cap_done <= 1'b1;
            end
        end
    end

    // A capture landing during COMMIT survives the flag clear and seeds the next frame.
    always_comb begin
        w_got_ones_n = ((r_state == COMMIT) ? 1'b0 : r_got_ones) | w_cap_ones;
        w_got_tens_n = ((r_state == COMMIT) ? 1'b0 : r_got_tens) | w_cap_tens;
        w_bad_n      = ((r_state == COMMIT) ? 1'b0 : r_bad)
                     | ((w_cap_ones | w_cap_tens) & w_dec[4]);
        w_ones_h_n   = w_cap_ones ? w_dec[3:0] : r_ones_h;
        w_tens_h_n   = w_cap_tens ? w_dec[3:0] : r_tens_h;
        w_value_n    = {w_tens_h_n, 3'b000} + {2'b00, w_tens_h_n, 1'b0}
                     + {3'b000, w_ones_h_n};
    end

    always_comb begin
        w_state_n    = r_state;
        w_commit_ok  = 1'b0;
        w_commit_bad = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_got_ones_n && w_got_tens_n) begin
                    w_state_n    = COMMIT;
                    w_commit_ok  = !w_bad_n;
                    w_commit_bad = w_bad_n;
                end
            end
            COMMIT:  w_state_n = COLLECT;
            default: w_state_n = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= COLLECT;
            r_ones_h   <= '0;
            r_tens_h   <= '0;
            r_got_ones <= 1'b0;
            r_got_tens <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ones_h   <= w_ones_h_n;
            r_tens_h   <= w_tens_h_n;
            r_got_ones <= w_got_ones_n;
            r_got_tens <= w_got_tens_n;
            r_bad      <= w_bad_n;
        end
    end

    // Outputs are loaded on the completing edge so they line up with the pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ones  <= '0;
            r_tens  <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_commit_ok;
            r_err   <= w_commit_bad;
            if (w_commit_ok) begin
                r_ones  <= w_ones_h_n;
                r_tens  <= w_tens_h_n;
                r_value <= w_value_n;
                r_cnt   <= '0;
            end else if (r_cnt != TW'(TIMEOUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic [1:0] r_dp_h, r_dp;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dp_h <= '0;
            r_dp   <= '0;
        end else begin
            if (w_cap_ones) r_dp_h[0] <= w_seg[0];
            if (w_cap_tens) r_dp_h[1] <= w_seg[0];
            if (w_commit_ok)
                r_dp <= {w_cap_tens ? w_seg[0] : r_dp_h[1],
                         w_cap_ones ? w_seg[0] : r_dp_h[0]};
        end
    end
    assign bus.o_dp = r_dp;
`else
    assign bus.o_dp = 2'b00;
`endif

    assign bus.o_ones  = r_ones;
    assign bus.o_tens  = r_tens;
    assign bus.o_value = r_value;
    assign bus.o_valid = r_valid;
    assign bus.o_err   = r_err;
    assign bus.o_stale = (r_cnt == TW'(TIMEOUT));

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the two-digit multiplexed 7-segment driver. It watches the segment and digit-select buses, waits for each digit's dwell to settle, and decodes the segment patterns back to BCD and binary. It reports complete two-digit frames to downstream logic. It is used for display loopback self-test and for reading a 7-segment output from another board.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive identical synchronized samples required before a digit is captured (≥2).
- `TIMEOUT`, default 27_000_000: number of cycles without a completed frame before `o_stale` asserts.
- `i_clk`, input, 1: system clock.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_seg`, input, 8: segment bus, active-high. Bit 7 = a … bit 1 = g, bit 0 = dp.
- `i_dig`, input, 4: digit select, active-low. `4'b1110` = ones, `4'b1101` = tens, anything else = blank/unknown.
- `o_ones`, output, 4: last committed ones digit, BCD.
- `o_tens`, output, 4: last committed tens digit, BCD.
- `o_value`, output, 7: `o_tens*10 + o_ones`, range 0–99.
- `o_dp`, output, 2: last committed decimal points. Bit 0 = ones, bit 1 = tens.
- `o_valid`, output, 1: one-cycle pulse when a new frame is committed.
- `o_err`, output, 1: one-cycle pulse when a frame is discarded for an invalid pattern.
- `o_stale`, output, 1: level; no frame committed for `TIMEOUT` cycles.

## Operation
- **Reset values.** All outputs are 0. All internal flags and counters are 0. Synchronizer stages are cleared to `i_seg=0`, `i_dig=4'hF`.
- **Input synchronization.** `{i_seg,i_dig}` pass through a 2-flop synchronizer to form `s`. The previous value of `s` is held in `p`.
- **Stability counter `stc`.**
  - `s != p`: `stc` clears to 0 and `cap_done` clears.
  - Otherwise `stc` increments, saturating at `STABLE_CYCLES`.
- **Capture.** Occurs when `stc == STABLE_CYCLES-1`, `s==p`, `!cap_done`, and `s.dig` is ones or tens.
  - The pattern is decoded into that digit's holding register, with dp masked.
  - `got_ones` or `got_tens` sets, the `bad` flag ORs in the invalid indication, and `cap_done` sets so each dwell captures only once.
- **Decode table** (`seg[7:1]`): 0=`1111110`, 1=`0110000`, 2=`1101101`, 3=`1111001`, 4=`0110011`, 5=`1011011`, 6=`1011111`, 7=`1110000`, 8=`1111111`, 9=`1111011`. Any other pattern is invalid.
- **FSM.**
  - **COLLECT**: captures accumulate. Move to COMMIT when `got_ones && got_tens`.
  - **COMMIT** (one cycle):
    - If `!bad`: update `o_ones`/`o_tens`/`o_value`/`o_dp`, pulse `o_valid`, clear the stale counter.
    - Else: pulse `o_err` and leave the outputs unchanged.
    - In both cases clear `got_*` and `bad`, then return to COLLECT.
- **Repeated digit.** If the same digit is captured twice before the other one arrives, the newer capture overwrites the older.
- **Value arithmetic.** `o_value = {tens,3'b0} + {tens,1'b0} + ones`, computed in 7 bits with no overflow for BCD inputs.
- **Stale counter.** Width is `$clog2(TIMEOUT+1)`. It increments every cycle and saturates at `TIMEOUT`. `o_stale = (cnt == TIMEOUT)`. A committed valid frame clears it; an `o_err` frame does not.
- **Blank/unknown selects.** Never captured. They only reset or advance `stc`.

## Timing
- A pin change reaches `s` two edges later.
- With pins constant from edge N, capture happens on edge N+2+`STABLE_CYCLES`.
- When a capture completes a frame, FSM enters COMMIT on that edge. `o_valid`/`o_err` and the updated outputs are high/visible during the following cycle. There is one cycle of latency from the completing capture.
- A glitch shorter than `STABLE_CYCLES` synchronized cycles causes no capture. A glitch after `cap_done` is set restarts the dwell and permits one re-capture.
- Capture and COMMIT in the same cycle: the capture lands in the holding register and counts toward the next frame.
- Reset mid-frame discards partial captures. Outputs return to 0 asynchronously.

## Configuration
- `SEG7_CAPTURE_DP_EN` defined: bit 0 of the segment bus is latched with each digit and committed to `o_dp`.
- Undefined: dp is ignored and `o_dp` is tied to `2'b00`. Decode is identical in both builds; dp never affects validity.

## Test plan
- Alternate ones=`8'b01100110`/`1110` and tens=`8'b11011010`/`1101`, 100-cycle dwells, after reset → one `o_valid` per ones+tens pair; `o_tens=2`, `o_ones=4`, `o_value=24`.
- Display 9 then 9 → `o_value=99`. Then 0/0 → `o_value=0`, `o_valid` pulse each frame.
- Tens pattern `8'b10010010` (invalid), ones=3 → `o_err` pulse, no `o_valid`, outputs keep their previous frame.
- Insert a 5-cycle `i_seg=8'hFF` glitch mid-dwell with `STABLE_CYCLES=16` → no capture of 8. The frame decodes the steady digits.
- Hold `i_dig=4'hF` for `TIMEOUT`=1000 (override) cycles → `o_stale=1` at cycle 1000. The next valid frame clears it.
- Assert `i_rst` after the ones capture, then release and send tens only → no `o_valid` until ones is re-captured. With `SEG7_CAPTURE_DP_EN` and dp=1 on ones → `o_dp=2'b01`.
